// File: rtl/bus_arbiter_if.sv
// Request/acknowledge bus bundle: NUM_PORTS requesters packed side by side, one shared read-data return.
// The arbiter uses a wide instance toward its clients and a single-port instance toward the memory.
interface bus_arbiter_if #(
    parameter int NUM_PORTS  = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_PORTS-1:0]            rq;
    logic [NUM_PORTS-1:0]            wr_ni;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dataW;
    logic [NUM_PORTS-1:0]            ack;
    logic [DATA_WIDTH-1:0]           dataR;

    modport master (output rq, wr_ni, address, dataW, input  ack, dataR);
    modport slave  (input  rq, wr_ni, address, dataW, output ack, dataR);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_CLIENTS rq/ack clients.
// Optional slave-ack timeout with err output is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  clients,
    bus_arbiter_if.master mem
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic          err
`endif
);
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    if (NUM_CLIENTS < 2 || TIMEOUT < 1) begin : g_param_check
        $error("bus_arbiter: NUM_CLIENTS must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic                    s_rq_q, s_rq_d;
    logic                    s_wr_ni_q, s_wr_ni_d;
    logic [ADDR_WIDTH-1:0]   s_address_q, s_address_d;
    logic [DATA_WIDTH-1:0]   s_dataW_q, s_dataW_d;
    logic [DATA_WIDTH-1:0]   dataR_q, dataR_d;
    logic [NUM_CLIENTS-1:0]  ack_q, ack_d;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
`endif

    // (base + off) mod NUM_CLIENTS, valid for base, off < NUM_CLIENTS
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_CLIENTS)) begin
            sum = sum - 32'(NUM_CLIENTS);
        end
        return sum[IW-1:0];
    endfunction

    // Requests rotated so that position 0 is the client at ptr.
    logic [NUM_CLIENTS-1:0] rq_rot;
    logic [IW-1:0]          rot_idx [NUM_CLIENTS];

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_rot
        assign rot_idx[gi] = wrap_idx(ptr_q, gi);
        assign rq_rot[gi]  = clients.rq[rot_idx[gi]];
    end

    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    always_comb begin
        pick_valid = |rq_rot;
        pick_idx   = ptr_q;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (rq_rot[k]) begin
                pick_idx = rot_idx[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        s_rq_d      = s_rq_q;
        s_wr_ni_d   = s_wr_ni_q;
        s_address_d = s_address_q;
        s_dataW_d   = s_dataW_q;
        dataR_d     = dataR_q;
        ack_d       = ack_q;
`ifdef BUS_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    s_wr_ni_d   = clients.wr_ni[pick_idx];
                    s_address_d = clients.address[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    s_dataW_d   = clients.dataW[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
                    s_rq_d      = 1'b1;
                    state_d     = BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                // A slave ack in the limit cycle still counts as a normal completion.
                if (mem.ack[0]) begin
                    s_rq_d  = 1'b0;
                    ack_d   = NUM_CLIENTS'(1) << grant_q;
                    state_d = DONE;
                    if (!s_wr_ni_q) begin
                        dataR_d = mem.dataR;
                    end
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    s_rq_d  = 1'b0;
                    err_d   = 1'b1;
                    ack_d   = NUM_CLIENTS'(1) << grant_q;
                    dataR_d = '0;
                    state_d = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (!clients.rq[grant_q]) begin
                    ack_d   = '0;
                    ptr_d   = wrap_idx(grant_q, 1);
                    state_d = IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            s_rq_q      <= 1'b0;
            s_wr_ni_q   <= 1'b0;
            s_address_q <= '0;
            s_dataW_q   <= '0;
            dataR_q     <= '0;
            ack_q       <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            s_rq_q      <= s_rq_d;
            s_wr_ni_q   <= s_wr_ni_d;
            s_address_q <= s_address_d;
            s_dataW_q   <= s_dataW_d;
            dataR_q     <= dataR_d;
            ack_q       <= ack_d;
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign clients.ack   = ack_q;
    assign clients.dataR = dataR_q;
    assign mem.rq        = s_rq_q;
    assign mem.wr_ni     = s_wr_ni_q;
    assign mem.address   = s_address_q;
    assign mem.dataW     = s_dataW_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign err           = err_q;
`endif

endmodule
